// File: rtl/pipe_lsu_pkg.sv
// pipe_lsu_pkg: shared encodings for the load/store unit.
//  - access size encodings (SZ_*)
//  - FSM state constants (ST_*)
//  - lane masks used by extract/merge
//  - latched request record and a request legality helper
package pipe_lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_ISSUE   = 3'd1;
    localparam logic [2:0] ST_CAPTURE = 3'd2;
    localparam logic [2:0] ST_WRITE   = 3'd3;
    localparam logic [2:0] ST_RESP    = 3'd4;

    localparam logic [31:0] BYTE_MASK = 32'h0000_00FF;
    localparam logic [31:0] HALF_MASK = 32'h0000_FFFF;

    // Only what is needed after accept: the word address goes straight to
    // mem_addr, and word stores take their data directly from the port.
    typedef struct packed {
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [1:0]  off;
        logic [15:0] wdata;
    } lsu_req_t;

    // Misaligned half/word or reserved size.
    function automatic logic is_bad_req(input logic [1:0] size, input logic [1:0] off);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return off[0];
            SZ_WORD: return off != 2'b00;
            SZ_RSVD: return 1'b1;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/pipe_lsu_lane.sv
// pipe_lsu_lane: combinational byte-lane logic for one 32-bit word.
//  i_word    word read from RAM (or forward buffer)
//  i_off     byte offset addr[1:0]
//  i_size    access size (SZ_*)
//  i_signed  sign-extend loads
//  i_wdata   store data, right-justified (low half only matters)
//  o_rdata   extracted and extended load value (word passes through)
//  o_merged  i_word with the store byte/half inserted at i_off
module pipe_lsu_lane
    import pipe_lsu_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_off,
    input  logic [1:0]  i_size,
    input  logic        i_signed,
    input  logic [15:0] i_wdata,
    output logic [31:0] o_rdata,
    output logic [31:0] o_merged
);

    logic [4:0]  w_sh;
    logic [15:0] w_shr;
    logic [31:0] w_mask;
    logic [31:0] w_ins;

    // Little-endian: byte lane n lives at bits [8n+7:8n].
    assign w_sh  = {i_off, 3'b000};
    assign w_shr = 16'(i_word >> w_sh);

    always_comb begin
        o_rdata = i_word;
        case (i_size)
            SZ_BYTE: o_rdata = {{24{i_signed & w_shr[7]}},  w_shr[7:0]};
            SZ_HALF: o_rdata = {{16{i_signed & w_shr[15]}}, w_shr[15:0]};
            default: o_rdata = i_word;
        endcase
    end

    // Word size leaves the mask empty: word stores never use the merge path.
    always_comb begin
        w_mask = '0;
        case (i_size)
            SZ_BYTE: w_mask = BYTE_MASK;
            SZ_HALF: w_mask = HALF_MASK;
            default: w_mask = '0;
        endcase
    end

    assign w_ins    = ({16'h0000, i_wdata} & w_mask) << w_sh;
    assign o_merged = (i_word & ~(w_mask << w_sh)) | w_ins;

endmodule

// File: rtl/pipe_lsu.sv
// pipe_lsu: load/store unit between the EX/MEM register and a word RAM with
// registered read. Handles lb/lbu/lh/lhu/lw/sb/sh/sw; sub-word stores are
// done as read-modify-write because the RAM only writes whole words.
// Ports:
//  clk, resetn                 clock, async active-low reset
//  req_valid/req_ready         request handshake (ready only in IDLE)
//  req_we/size/signed/addr/wdata  request fields
//  rsp_valid/rsp_rdata/rsp_err one-cycle completion with load data / error
//  stall                       ~req_ready, pipeline hold
//  mem_we/mem_addr/mem_din     registered RAM controls
//  mem_dout                    RAM read data, RAM_LAT cycles after mem_addr
// Config: define PIPE_LSU_FWD_EN for a 1-entry last-store buffer that lets a
// load to the last written word complete without touching the RAM.
module pipe_lsu
    import pipe_lsu_pkg::*;
#(
    parameter int RAM_LAT = 1,
    parameter int IDX_W   = 5
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        stall,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_din,
    input  logic [31:0] mem_dout
);

    if (RAM_LAT < 1 || RAM_LAT > 3) begin : g_bad_lat
        $error("pipe_lsu: RAM_LAT must be 1..3");
    end
    if (IDX_W < 1 || IDX_W > 30) begin : g_bad_idx
        $error("pipe_lsu: IDX_W must be 1..30");
    end

    logic [2:0]  r_state;
    lsu_req_t    r_req;
    logic [1:0]  r_cnt;
    logic        r_cap_ph;
    logic [31:0] r_rdword;
    logic        r_rsp_valid;
    logic [31:0] r_rsp_rdata;
    logic        r_rsp_err;
    logic        r_mem_we;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_din;

    logic        w_bad;
    logic [31:0] w_ln_word;
    logic [1:0]  w_ln_off;
    logic [1:0]  w_ln_size;
    logic        w_ln_signed;
    logic [31:0] w_ln_rdata;
    logic [31:0] w_ln_merged;

    assign w_bad = is_bad_req(req_size, req_addr[1:0]);

`ifdef PIPE_LSU_FWD_EN
    logic             r_fwd_vld;
    logic [IDX_W-1:0] r_fwd_idx;
    logic [31:0]      r_fwd_data;
    logic             w_fwd_hit;

    assign w_fwd_hit = r_fwd_vld && (r_fwd_idx == req_addr[IDX_W+1:2]);

    // Captures every word actually written, including merged sub-word stores.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_fwd_vld  <= 1'b0;
            r_fwd_idx  <= '0;
            r_fwd_data <= '0;
        end else if (r_state == ST_WRITE) begin
            r_fwd_vld  <= 1'b1;
            r_fwd_idx  <= r_mem_addr[IDX_W+1:2];
            r_fwd_data <= r_mem_din;
        end
    end
`endif

    // One lane unit serves RAM loads, the store merge and (with the buffer)
    // forwarded loads, which are extracted from the live request in IDLE.
    always_comb begin
        w_ln_word   = r_req.we ? r_rdword : mem_dout;
        w_ln_off    = r_req.off;
        w_ln_size   = r_req.size;
        w_ln_signed = r_req.sgn;
`ifdef PIPE_LSU_FWD_EN
        if (r_state == ST_IDLE) begin
            w_ln_word   = r_fwd_data;
            w_ln_off    = req_addr[1:0];
            w_ln_size   = req_size;
            w_ln_signed = req_signed;
        end
`endif
    end

    pipe_lsu_lane u_lane (
        .i_word   (w_ln_word),
        .i_off    (w_ln_off),
        .i_size   (w_ln_size),
        .i_signed (w_ln_signed),
        .i_wdata  (r_req.wdata),
        .o_rdata  (w_ln_rdata),
        .o_merged (w_ln_merged)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= ST_IDLE;
            r_req       <= '0;
            r_cnt       <= '0;
            r_cap_ph    <= 1'b0;
            r_rdword    <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_din   <= '0;
        end else begin
            // Both are single-cycle pulses set on entry to WRITE/RESP.
            r_rsp_valid <= 1'b0;
            r_mem_we    <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_req       <= '{we: req_we, size: req_size, sgn: req_signed,
                                         off: req_addr[1:0], wdata: req_wdata[15:0]};
                        r_rsp_rdata <= '0;
                        r_rsp_err   <= 1'b0;
                        if (w_bad) begin
                            r_state     <= ST_RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                        end else if (req_we && req_size == SZ_WORD) begin
                            r_state     <= ST_WRITE;
                            r_mem_we    <= 1'b1;
                            r_rsp_valid <= 1'b1;
                            r_mem_addr  <= {req_addr[31:2], 2'b00};
                            r_mem_din   <= req_wdata;
`ifdef PIPE_LSU_FWD_EN
                        end else if (!req_we && w_fwd_hit) begin
                            r_state     <= ST_RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_rdata <= w_ln_rdata;
`endif
                        end else begin
                            r_state    <= ST_ISSUE;
                            r_mem_addr <= {req_addr[31:2], 2'b00};
                            r_cnt      <= 2'(RAM_LAT - 1);
                        end
                    end
                end
                ST_ISSUE: begin
                    if (r_cnt == 2'd0) begin
                        r_state  <= ST_CAPTURE;
                        r_cap_ph <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt - 2'd1;
                    end
                end
                ST_CAPTURE: begin
                    if (!r_req.we) begin
                        r_state     <= ST_RESP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_rdata <= w_ln_rdata;
                    end else if (!r_cap_ph) begin
                        // Stores register the RAM word first so the RAM
                        // output path does not run through the merge mux.
                        r_rdword <= mem_dout;
                        r_cap_ph <= 1'b1;
                    end else begin
                        r_state     <= ST_WRITE;
                        r_mem_we    <= 1'b1;
                        r_rsp_valid <= 1'b1;
                        r_mem_din   <= w_ln_merged;
                    end
                end
                ST_WRITE: r_state <= ST_IDLE;
                ST_RESP:  r_state <= ST_IDLE;
                default:  r_state <= ST_IDLE;
            endcase
        end
    end

    assign req_ready = (r_state == ST_IDLE);
    assign stall     = ~req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_din   = r_mem_din;

endmodule

// File: tb/tb_pipe_lsu.sv
module tb_pipe_lsu;
    localparam int LAT = 1;

    logic        clk;
    logic        resetn;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        stall;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_din;
    logic [31:0] mem_dout;

    int n_chk;
    int n_err;

    // word RAM (registered read, 1 cycle) with a bench preload port
    logic [31:0] ram [32];
    logic [31:0] ram_q;
    logic        pre_we;
    logic [4:0]  pre_idx;
    logic [31:0] pre_dat;

    // reference model state
    bit [31:0] ref_mem [32];
    bit        fwd_v;
    int        fwd_i;

    pipe_lsu #(.RAM_LAT(LAT), .IDX_W(5)) dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .stall(stall), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_din(mem_din), .mem_dout(mem_dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pre_we) ram[pre_idx] <= pre_dat;
        else if (mem_we) ram[mem_addr[6:2]] <= mem_din;
        ram_q <= ram[mem_addr[6:2]];
    end
    assign mem_dout = ram_q;

    // Expected outcome of one request, from the architectural rules.
    task automatic model_req(input bit we, input bit [1:0] sz, input bit sg, input bit [31:0] a,
                             input bit [31:0] wd, output bit [31:0] e_rd, output bit e_err,
                             output int e_lat, output bit e_wr, output bit [31:0] e_din);
        int idx, off;
        bit [31:0] w, m, v;
        idx = int'(a[6:2]);
        off = int'(a[1:0]);
        e_rd = 0; e_err = 0; e_wr = 0; e_din = 0; e_lat = 1;
        w = ref_mem[idx];
        if (sz == 2'd3 || (sz == 2'd1 && off % 2 != 0) || (sz == 2'd2 && off != 0)) begin
            e_err = 1;
        end else if (!we) begin
            if (sz == 2'd0) begin
                v = (w >> (8 * off)) & 32'hFF;
                if (sg && v >= 32'h80) v = v | 32'hFFFF_FF00;
            end else if (sz == 2'd1) begin
                v = (w >> (8 * off)) & 32'hFFFF;
                if (sg && v >= 32'h8000) v = v | 32'hFFFF_0000;
            end else begin
                v = w;
            end
            e_rd = v;
            e_lat = 2 + LAT;
`ifdef PIPE_LSU_FWD_EN
            if (fwd_v && fwd_i == idx) e_lat = 1;
`endif
        end else begin
            if (sz == 2'd2) begin
                v = wd;
                e_lat = 1;
            end else begin
                m = (sz == 2'd0) ? 32'hFF : 32'hFFFF;
                v = (w & ~(m << (8 * off))) | ((wd & m) << (8 * off));
                e_lat = 3 + LAT;
            end
            e_wr = 1;
            e_din = v;
            ref_mem[idx] = v;
            fwd_v = 1;
            fwd_i = idx;
        end
    endtask

    // Drive one request and observe it to completion plus one cycle.
    task automatic do_req(input bit we, input bit [1:0] sz, input bit sg, input bit [31:0] a,
                          input bit [31:0] wd, output int lat, output bit [31:0] rd, output bit er,
                          output int nwe, output bit [31:0] wa, output bit [31:0] wdin,
                          output bit rdy_after);
        int guard;
        lat = -1; rd = 0; er = 0; nwe = 0; wa = 0; wdin = 0; rdy_after = 0;
        guard = 0;
        while (!req_ready && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        req_valid = 1; req_we = we; req_size = sz; req_signed = sg;
        req_addr = a; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 0;
        for (int k = 1; k <= 12 && lat < 0; k++) begin
            if (mem_we) begin
                nwe++;
                wa = mem_addr;
                wdin = mem_din;
            end
            if (rsp_valid) begin
                lat = k;
                rd = rsp_rdata;
                er = rsp_err;
            end else begin
                @(posedge clk); #1;
            end
        end
        @(posedge clk); #1;
        rdy_after = req_ready && !rsp_valid;
        if (mem_we) nwe++;
    endtask

    task automatic test_reset;
        resetn = 0;
        repeat (2) @(posedge clk);
        #1;
        n_chk++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", req_ready); end
        n_chk++; if (stall !== 1'b0) begin n_err++; $display("FAIL reset_stall: got %b want 0", stall); end
        n_chk++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        n_chk++; if (rsp_rdata !== 32'h0) begin n_err++; $display("FAIL reset_rsp_rdata: got %h want 0", rsp_rdata); end
        n_chk++; if (rsp_err !== 1'b0) begin n_err++; $display("FAIL reset_rsp_err: got %b want 0", rsp_err); end
        n_chk++; if (mem_we !== 1'b0) begin n_err++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
        n_chk++; if (mem_addr !== 32'h0) begin n_err++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
        n_chk++; if (mem_din !== 32'h0) begin n_err++; $display("FAIL reset_mem_din: got %h want 0", mem_din); end
        resetn = 1;
        fwd_v = 0;
        @(posedge clk); #1;
        n_chk++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL reset_release_ready: got %b want 1", req_ready); end
    endtask

    task automatic preload;
        pre_we = 1;
        for (int i = 0; i < 32; i++) begin
            pre_idx = 5'(i);
            pre_dat = $urandom;
            ref_mem[i] = pre_dat;
            @(posedge clk); #1;
        end
        pre_we = 0;
    endtask

    task automatic test_directed;
        bit        t_we [7] = '{1, 0, 0, 0, 1, 0, 0};
        bit [1:0]  t_sz [7] = '{2'd2, 2'd0, 2'd0, 2'd1, 2'd0, 2'd2, 2'd1};
        bit        t_sg [7] = '{0, 1, 0, 0, 0, 0, 1};
        bit [31:0] t_a  [7] = '{32'h08, 32'h0B, 32'h08, 32'h0A, 32'h09, 32'h06, 32'h03};
        bit [31:0] t_wd [7] = '{32'hDEADBEEF, 0, 0, 0, 32'h11, 0, 0};
        bit [31:0] t_rd [7] = '{0, 32'hFFFFFFDE, 32'h000000EF, 32'h0000DEAD, 0, 0, 0};
        bit        t_er [7] = '{0, 0, 0, 0, 0, 1, 1};
        bit [31:0] t_dn [7] = '{32'hDEADBEEF, 0, 0, 0, 32'hDEAD11EF, 0, 0};
        bit [31:0] e_rd, e_din, rd, wa, wdin;
        bit e_err, e_wr, er, ra;
        int e_lat, lat, nwe;
        for (int i = 0; i < 7; i++) begin
            do_req(t_we[i], t_sz[i], t_sg[i], t_a[i], t_wd[i], lat, rd, er, nwe, wa, wdin, ra);
            model_req(t_we[i], t_sz[i], t_sg[i], t_a[i], t_wd[i], e_rd, e_err, e_lat, e_wr, e_din);
            n_chk++; if (rd !== t_rd[i]) begin n_err++; $display("FAIL dir_rdata[%0d]: got %h want %h", i, rd, t_rd[i]); end
            n_chk++; if (er !== t_er[i]) begin n_err++; $display("FAIL dir_err[%0d]: got %b want %b", i, er, t_er[i]); end
            n_chk++; if (lat !== e_lat) begin n_err++; $display("FAIL dir_latency[%0d]: got %0d want %0d", i, lat, e_lat); end
            n_chk++; if (nwe !== int'(t_we[i] && !t_er[i])) begin n_err++; $display("FAIL dir_we_count[%0d]: got %0d want %0d", i, nwe, int'(t_we[i] && !t_er[i])); end
            n_chk++; if (ra !== 1'b1) begin n_err++; $display("FAIL dir_ready_after[%0d]: got %b want 1", i, ra); end
            if (t_we[i]) begin
                n_chk++; if (wdin !== t_dn[i]) begin n_err++; $display("FAIL dir_mem_din[%0d]: got %h want %h", i, wdin, t_dn[i]); end
                n_chk++; if (wa !== 32'h08) begin n_err++; $display("FAIL dir_mem_addr[%0d]: got %h want 00000008", i, wa); end
            end
        end
    endtask

    task automatic test_store_load_pair;
        bit [31:0] e_rd, e_din, rd, wa, wdin;
        bit e_err, e_wr, er, ra;
        int e_lat, lat, nwe;
        do_req(1, 2'd2, 0, 32'h10, 32'h12345678, lat, rd, er, nwe, wa, wdin, ra);
        model_req(1, 2'd2, 0, 32'h10, 32'h12345678, e_rd, e_err, e_lat, e_wr, e_din);
        n_chk++; if (lat !== 1) begin n_err++; $display("FAIL pair_sw_latency: got %0d want 1", lat); end
        do_req(0, 2'd2, 0, 32'h10, 0, lat, rd, er, nwe, wa, wdin, ra);
        model_req(0, 2'd2, 0, 32'h10, 0, e_rd, e_err, e_lat, e_wr, e_din);
        n_chk++; if (rd !== 32'h12345678) begin n_err++; $display("FAIL pair_lw_rdata: got %h want 12345678", rd); end
        n_chk++; if (lat !== e_lat) begin n_err++; $display("FAIL pair_lw_latency: got %0d want %0d", lat, e_lat); end
`ifdef PIPE_LSU_FWD_EN
        n_chk++; if (lat !== 1) begin n_err++; $display("FAIL pair_fwd_latency: got %0d want 1", lat); end
`endif
        n_chk++; if (nwe !== 0) begin n_err++; $display("FAIL pair_lw_no_write: got %0d want 0", nwe); end
    endtask

    task automatic test_random(input int n);
        bit we, sg, e_err, e_wr, er, ra;
        bit [1:0] sz;
        bit [31:0] a, wd, e_rd, e_din, rd, wa, wdin;
        int e_lat, lat, nwe;
        for (int i = 0; i < n; i++) begin
            we = 1'($urandom_range(0, 1));
            sg = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            if (sz == 2'd3 && $urandom_range(0, 3) != 0) sz = 2'd2;
            a = {25'd0, 5'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'd1) a[0] = 1'b0;
                if (sz == 2'd2) a[1:0] = 2'b00;
            end
            if ($urandom_range(0, 7) == 0) a[31:7] = 25'($urandom);
            wd = $urandom;
            do_req(we, sz, sg, a, wd, lat, rd, er, nwe, wa, wdin, ra);
            model_req(we, sz, sg, a, wd, e_rd, e_err, e_lat, e_wr, e_din);
            n_chk++; if (lat !== e_lat) begin n_err++; $display("FAIL rnd_latency[%0d]: got %0d want %0d", i, lat, e_lat); end
            n_chk++; if (rd !== e_rd) begin n_err++; $display("FAIL rnd_rdata[%0d]: got %h want %h", i, rd, e_rd); end
            n_chk++; if (er !== e_err) begin n_err++; $display("FAIL rnd_err[%0d]: got %b want %b", i, er, e_err); end
            n_chk++; if (nwe !== int'(e_wr)) begin n_err++; $display("FAIL rnd_we_count[%0d]: got %0d want %0d", i, nwe, int'(e_wr)); end
            n_chk++; if (ra !== 1'b1) begin n_err++; $display("FAIL rnd_ready_after[%0d]: got %b want 1", i, ra); end
            if (e_wr) begin
                n_chk++; if (wa !== {a[31:2], 2'b00}) begin n_err++; $display("FAIL rnd_mem_addr[%0d]: got %h want %h", i, wa, {a[31:2], 2'b00}); end
                n_chk++; if (wdin !== e_din) begin n_err++; $display("FAIL rnd_mem_din[%0d]: got %h want %h", i, wdin, e_din); end
            end
        end
    endtask

    // A store presented while a load is in flight must be dropped.
    task automatic test_busy_ignore;
        bit [31:0] e_rd, e_din, rd, wa, wdin, obs;
        bit e_err, e_wr, er, ra;
        int e_lat, lat, nwe, guard, wseen;
        guard = 0;
        while (!req_ready && guard < 50) begin @(posedge clk); #1; guard++; end
        req_valid = 1; req_we = 0; req_size = 2'd2; req_signed = 0; req_addr = 32'h20; req_wdata = 0;
        @(posedge clk); #1;
        model_req(0, 2'd2, 0, 32'h20, 0, e_rd, e_err, e_lat, e_wr, e_din);
        lat = -1; wseen = 0; obs = 0;
        for (int k = 1; k <= 12 && lat < 0; k++) begin
            if (mem_we) wseen++;
            if (rsp_valid) begin
                lat = k;
                obs = rsp_rdata;
                req_valid = 0;
            end else begin
                req_valid = 1; req_we = 1; req_size = 2'd2; req_addr = 32'h24; req_wdata = 32'hA5A5A5A5;
                @(posedge clk); #1;
            end
        end
        req_valid = 0;
        n_chk++; if (lat !== e_lat) begin n_err++; $display("FAIL busy_latency: got %0d want %0d", lat, e_lat); end
        n_chk++; if (obs !== e_rd) begin n_err++; $display("FAIL busy_rdata: got %h want %h", obs, e_rd); end
        n_chk++; if (wseen !== 0) begin n_err++; $display("FAIL busy_no_write: got %0d want 0", wseen); end
        @(posedge clk); #1;
        n_chk++; if (mem_we !== 1'b0) begin n_err++; $display("FAIL busy_no_late_write: got %b want 0", mem_we); end
        do_req(0, 2'd2, 0, 32'h24, 0, lat, rd, er, nwe, wa, wdin, ra);
        model_req(0, 2'd2, 0, 32'h24, 0, e_rd, e_err, e_lat, e_wr, e_din);
        n_chk++; if (rd !== e_rd) begin n_err++; $display("FAIL busy_word_intact: got %h want %h", rd, e_rd); end
    endtask

    task automatic test_reset_mid_write;
        bit [31:0] e_rd, e_din, rd, wa, wdin;
        bit e_err, e_wr, er, ra;
        int e_lat, lat, nwe, guard;
        guard = 0;
        while (!req_ready && guard < 50) begin @(posedge clk); #1; guard++; end
        req_valid = 1; req_we = 1; req_size = 2'd1; req_signed = 0; req_addr = 32'h16; req_wdata = 32'h0000BEEF;
        @(posedge clk); #1;
        req_valid = 0;
        guard = 0;
        while (!mem_we && guard < 20) begin @(posedge clk); #1; guard++; end
        n_chk++; if (mem_we !== 1'b1) begin n_err++; $display("FAIL rstw_reach_write: got %b want 1", mem_we); end
        resetn = 0;
        #1;
        n_chk++; if (mem_we !== 1'b0) begin n_err++; $display("FAIL rstw_we_drop: got %b want 0", mem_we); end
        n_chk++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rstw_no_rsp: got %b want 0", rsp_valid); end
        n_chk++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL rstw_idle: got %b want 1", req_ready); end
        @(posedge clk); #1;
        resetn = 1;
        fwd_v = 0;
        @(posedge clk); #1;
        n_chk++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL rstw_ready_release: got %b want 1", req_ready); end
        // the aborted store must not have changed the word (model untouched)
        do_req(0, 2'd2, 0, 32'h14, 0, lat, rd, er, nwe, wa, wdin, ra);
        model_req(0, 2'd2, 0, 32'h14, 0, e_rd, e_err, e_lat, e_wr, e_din);
        n_chk++; if (rd !== e_rd) begin n_err++; $display("FAIL rstw_word_intact: got %h want %h", rd, e_rd); end
        n_chk++; if (lat !== e_lat) begin n_err++; $display("FAIL rstw_latency: got %0d want %0d", lat, e_lat); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        clk = 0; resetn = 0;
        req_valid = 0; req_we = 0; req_size = 0; req_signed = 0; req_addr = 0; req_wdata = 0;
        pre_we = 0; pre_idx = 0; pre_dat = 0;
        n_chk = 0; n_err = 0; fwd_v = 0; fwd_i = 0;
        #1;
        test_reset;
        preload;
        test_directed;
        test_store_load_pair;
        test_random(300);
        test_busy_ignore;
        test_reset_mid_write;
        test_random(60);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
